// File: rtl/tow_pkg.sv
// tow_pkg: shared types and constant helpers for the tug-of-war playfield.
//   state_e    - game FSM states
//   pos_width  - bits needed to index an N-LED playfield
//   center_idx - index of the centre LED of an odd-length playfield
package tow_pkg;

    typedef enum logic [1:0] {
        StPlay      = 2'd0,
        StHold      = 2'd1,
        StMatchOver = 2'd2
    } state_e;

    function automatic int unsigned pos_width(input int unsigned n);
        return (n > 2) ? unsigned'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned center_idx(input int unsigned n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/tow_counter.sv
// tow_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   reset - asynchronous active-low reset (count -> 0)
//   inc   - increment by one when not saturated
//   clr   - synchronous clear, wins over inc
//   count - current value
module tow_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tow_field.sv
// tow_field: tug-of-war playfield. A single lit LED is pulled toward index N_LEDS-1 by
// left_press and toward index 0 by right_press; pulling past an edge wins the round.
// After a win the edge LED is held for HOLD_CYCLES cycles, then play restarts at the
// centre, or the match ends once a player reaches WIN_SCORE.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   left_press, right_press - single-cycle conditioned button pulses
//   clear_match             - starts a new match while the match is over
//   leds                    - one-hot playfield
//   left_score, right_score - round wins this match
//   round_win               - one-cycle pulse following the winning edge
//   winner                  - 1 = left, 0 = right (last round winner)
//   match_over              - high while the match is over
module tow_field
    import tow_pkg::*;
#(
    parameter int unsigned N_LEDS      = 9,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left_press,
    input  logic               right_press,
    input  logic               clear_match,
    output logic [N_LEDS-1:0]  leds,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               round_win,
    output logic               winner,
    output logic               match_over
);

    localparam int unsigned PosW  = pos_width(N_LEDS);
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PosW-1:0]    Center   = PosW'(center_idx(N_LEDS));
    localparam logic [PosW-1:0]    MaxPos   = PosW'(N_LEDS - 1);
    localparam logic [HoldW-1:0]   HoldInit = HoldW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

    state_e           state;
    logic [PosW-1:0]  pos;
    logic [HoldW-1:0] hold_cnt;

    logic left_only, right_only;
    logic left_wins, right_wins;
    logic new_match, match_done;

    // Simultaneous presses cancel each other.
    assign left_only  = left_press & ~right_press;
    assign right_only = right_press & ~left_press;

    assign left_wins  = (state == StPlay) && left_only && (pos == MaxPos);
    assign right_wins = (state == StPlay) && right_only && (pos == '0);
    assign new_match  = (state == StMatchOver) && clear_match;

    // Scores are already updated when HOLD ends, so this sees the final tally.
    assign match_done = (left_score == WinScore) || (right_score == WinScore);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StPlay;
            pos        <= Center;
            hold_cnt   <= '0;
            winner     <= 1'b0;
            round_win  <= 1'b0;
            match_over <= 1'b0;
        end else begin
            round_win <= 1'b0;
            unique case (state)
                StPlay: begin
                    if (left_wins || right_wins) begin
                        winner    <= left_wins;
                        round_win <= 1'b1;
                        hold_cnt  <= HoldInit;
                        state     <= StHold;
                    end else if (left_only) begin
                        pos <= pos + 1'b1;
                    end else if (right_only) begin
                        pos <= pos - 1'b1;
                    end
                end
                StHold: begin
                    if (hold_cnt == '0) begin
                        if (match_done) begin
                            match_over <= 1'b1;
                            state      <= StMatchOver;
                        end else begin
                            pos   <= Center;
                            state <= StPlay;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                StMatchOver: begin
                    if (clear_match) begin
                        pos        <= Center;
                        match_over <= 1'b0;
                        state      <= StPlay;
                    end
                end
                default: state <= StPlay;
            endcase
        end
    end

    tow_counter #(
        .WIDTH (SCORE_W)
    ) u_left_score (
        .clk   (clk),
        .reset (reset),
        .inc   (left_wins),
        .clr   (new_match),
        .count (left_score)
    );

    tow_counter #(
        .WIDTH (SCORE_W)
    ) u_right_score (
        .clk   (clk),
        .reset (reset),
        .inc   (right_wins),
        .clr   (new_match),
        .count (right_score)
    );

    always_comb begin
        leds = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            leds[i] = (pos == PosW'(i));
        end
    end

endmodule

// File: tb/tb_tow_field.sv
// tb_tow_field: directed, table-driven check of tow_field with N_LEDS=5, WIN_SCORE=3,
// HOLD_CYCLES=2. Inputs change on the falling edge; outputs are sampled 1 time unit
// after each rising edge.
module tb_tow_field;

    logic       clk = 1'b0;
    logic       reset;
    logic       left_press, right_press, clear_match;
    logic [4:0] leds;
    logic [2:0] left_score, right_score;
    logic       round_win, winner, match_over;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       c;
        logic [4:0] leds;
        logic [2:0] ls;
        logic [2:0] rs;
        logic       rw;
        logic       w;
        logic       mo;
    } vec_t;

    localparam int NVec = 26;
    vec_t vecs [NVec];

    tow_field #(
        .N_LEDS      (5),
        .SCORE_W     (3),
        .WIN_SCORE   (3),
        .HOLD_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .left_press  (left_press),
        .right_press (right_press),
        .clear_match (clear_match),
        .leds        (leds),
        .left_score  (left_score),
        .right_score (right_score),
        .round_win   (round_win),
        .winner      (winner),
        .match_over  (match_over)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic l, input logic r, input logic c,
                                input logic [4:0] e_leds, input int ls, input int rs,
                                input logic rw, input logic w, input logic mo);
        vec_t v;
        v.l = l; v.r = r; v.c = c;
        v.leds = e_leds; v.ls = 3'(ls); v.rs = 3'(rs);
        v.rw = rw; v.w = w; v.mo = mo;
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        vectors++;
        if (leds !== e.leds || left_score !== e.ls || right_score !== e.rs ||
            round_win !== e.rw || winner !== e.w || match_over !== e.mo) begin
            miscompares++;
            $display("FAIL %s: got leds=%b ls=%0d rs=%0d rw=%b w=%b mo=%b, want leds=%b ls=%0d rs=%0d rw=%b w=%b mo=%b",
                     name, leds, left_score, right_score, round_win, winner, match_over,
                     e.leds, e.ls, e.rs, e.rw, e.w, e.mo);
        end
    endtask

    // Drive one cycle of inputs, then sample after the rising edge.
    task automatic step(input logic l, input logic r, input logic c);
        @(negedge clk);
        left_press  = l;
        right_press = r;
        clear_match = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Columns: l r c | leds ls rs rw w mo
        vecs[0]  = mk(1, 0, 0, 5'b01000, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 5'b10000, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 5'b10000, 0, 0, 0, 0, 0); // tie at edge: no win
        vecs[3]  = mk(1, 0, 0, 5'b10000, 1, 0, 1, 1, 0); // left wins round
        vecs[4]  = mk(1, 0, 0, 5'b10000, 1, 0, 0, 1, 0); // HOLD ignores press
        vecs[5]  = mk(0, 1, 0, 5'b00100, 1, 0, 0, 1, 0); // HOLD ends, press ignored
        vecs[6]  = mk(0, 0, 1, 5'b00100, 1, 0, 0, 1, 0); // clear in PLAY ignored
        vecs[7]  = mk(0, 1, 0, 5'b00010, 1, 0, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 5'b00001, 1, 0, 0, 1, 0);
        vecs[9]  = mk(0, 1, 0, 5'b00001, 1, 1, 1, 0, 0); // right wins round
        vecs[10] = mk(0, 0, 1, 5'b00001, 1, 1, 0, 0, 0); // clear in HOLD ignored
        vecs[11] = mk(0, 0, 0, 5'b00100, 1, 1, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 5'b01000, 1, 1, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 5'b10000, 1, 1, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 5'b10000, 2, 1, 1, 1, 0);
        vecs[15] = mk(0, 0, 0, 5'b10000, 2, 1, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 5'b00100, 2, 1, 0, 1, 0);
        vecs[17] = mk(1, 0, 0, 5'b01000, 2, 1, 0, 1, 0);
        vecs[18] = mk(1, 0, 0, 5'b10000, 2, 1, 0, 1, 0);
        vecs[19] = mk(1, 0, 0, 5'b10000, 3, 1, 1, 1, 0); // match-winning round
        vecs[20] = mk(0, 0, 0, 5'b10000, 3, 1, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 5'b10000, 3, 1, 0, 1, 1); // match over
        vecs[22] = mk(0, 1, 0, 5'b10000, 3, 1, 0, 1, 1);
        vecs[23] = mk(1, 0, 0, 5'b10000, 3, 1, 0, 1, 1);
        vecs[24] = mk(0, 0, 1, 5'b00100, 0, 0, 0, 1, 0); // new match, winner kept
        vecs[25] = mk(1, 0, 0, 5'b01000, 0, 0, 0, 1, 0);

        reset       = 1'b0;
        left_press  = 1'b0;
        right_press = 1'b0;
        clear_match = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_state", mk(0, 0, 0, 5'b00100, 0, 0, 0, 0, 0));

        for (int i = 0; i < NVec; i++) begin
            step(vecs[i].l, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d", i), vecs[i]);
        end

        // Build left_score=2, then assert reset mid-HOLD.
        step(1, 0, 0);
        step(1, 0, 0);
        check("seq_win1", mk(0, 0, 0, 5'b10000, 1, 0, 1, 1, 0));
        step(0, 0, 0);
        step(0, 0, 0);
        check("seq_center", mk(0, 0, 0, 5'b00100, 1, 0, 0, 1, 0));
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("seq_win2", mk(0, 0, 0, 5'b10000, 2, 0, 1, 1, 0));
        step(0, 0, 0);
        check("seq_in_hold", mk(0, 0, 0, 5'b10000, 2, 0, 0, 1, 0));

        #2;
        reset = 1'b0;
        #1;
        check("async_reset", mk(0, 0, 0, 5'b00100, 0, 0, 0, 0, 0));

        // First edge after release must act on a press.
        @(negedge clk);
        reset       = 1'b1;
        left_press  = 1'b1;
        right_press = 1'b0;
        clear_match = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_press", mk(0, 0, 0, 5'b01000, 0, 0, 0, 0, 0));
        step(0, 1, 0);
        check("after_reset_right", mk(0, 0, 0, 5'b00100, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
